mux_nt1_pipe: RTL and testbench

Parametrised N-to-1 data selector with a registered output stage and a valid/ready handshake on every input channel and on the output. It generalises the 2:1 64-bit ALU-path multiplexers to CH channels of WIDTH bits. It adds a round-robin mode alongside fixed selection, plus a saturating transfer counter. It sits between the ALU result sources and the writeback/display consumers, which may apply backpressure.

---
 rtl/mux_nt1_pipe.sv | 166 ++++++++++++++++
 tb/tb_mux_nt1_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nt1_pipe.sv
// Purpose : CH-to-1 valid/ready data selector, fixed (sel) or round-robin pick, registered output.
// Latency : 1 cycle; a word accepted at edge n is on out_data/out_valid right after edge n.
// Backpr. : out_valid && !out_ready drops every in_ready; output register holds until taken.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_data[CH*WIDTH] channel i at [i*WIDTH +: WIDTH]; in_valid/in_ready per channel
//   sel, mode         mode 0: channel sel (sel >= CH picks nothing); mode 1: round-robin
//   out_data/out_ch   registered word and the channel that supplied it
//   out_valid/out_ready output handshake; xfer_cnt counts output takes, saturating at 16'hFFFF
//
// Build option: define MUX_SEL_INVERT_EN to make fixed mode pick channel CH-1-sel
// (legacy 2:1 polarity). The range check still uses the raw sel; round-robin is unaffected.
module mux_nt1_pipe #(
    parameter int WIDTH = 64,
    parameter int CH    = 4,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic                  mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_ch,
    output logic [15:0]           xfer_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [15:0]      xfer_cnt_q,  xfer_cnt_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    // Unpacked view of the flat input bus so the selected word is a plain array read.
    logic [WIDTH-1:0] ch_dat [CH];

    for (genvar g = 0; g < CH; g++) begin : g_unpack
        assign ch_dat[g] = in_data[g*WIDTH +: WIDTH];
    end

    // (base + off) mod CH. base is always < CH and off <= CH, so one subtraction is enough.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= CH) begin
            s = s - CH;
        end
        return SELW'(s);
    endfunction

    // ------------------------------------------------------------------
    // Channel choice (combinational from the current inputs)
    // ------------------------------------------------------------------
    logic            pick_vld;
    logic [SELW-1:0] pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        if (!mode) begin
            // Fixed mode: the channel is offered a slot even if it is not valid yet.
            if (int'(sel) < CH) begin
                pick_vld = 1'b1;
`ifdef MUX_SEL_INVERT_EN
                pick_idx = SELW'(CH - 1 - int'(sel));
`else
                pick_idx = sel;
`endif
            end
        end else begin
            // Round-robin: first valid channel at or after rr_ptr, wrapping.
            for (int k = 0; k < CH; k++) begin
                if (!pick_vld && in_valid[wrap_add(rr_ptr_q, k)]) begin
                    pick_vld = 1'b1;
                    pick_idx = wrap_add(rr_ptr_q, k);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic space;
    logic accept;
    logic take;

    // The output slot can take a new word if it is empty or being drained this cycle.
    assign space  = !out_valid_q || out_ready;
    assign accept = !rst && space && pick_vld && in_valid[pick_idx];
    assign take   = out_valid_q && out_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = !rst && space && pick_vld && (pick_idx == SELW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_cnt_d  = xfer_cnt_q;

        if (accept) begin
            // Also covers take+accept in one cycle: new word overwrites, no bubble.
            out_data_d  = ch_dat[pick_idx];
            out_ch_d    = pick_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = wrap_add(pick_idx, 1);
            end
        end else if (take) begin
            out_valid_d = 1'b0;
        end

        if (take && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            xfer_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            xfer_cnt_q  <= xfer_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign xfer_cnt  = xfer_cnt_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

    a_ptr_range: assert property (@(posedge clk) int'(rr_ptr_q) < CH);

    a_hold_stall: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_ch_q)));

endmodule

// File: tb/tb_mux_nt1_pipe.sv
module tb_mux_nt1_pipe;

`ifdef MUX_SEL_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // 4-channel, 64-bit instance
    logic [255:0] d4 = '0;
    logic [3:0]   v4 = '0, r4;
    logic [1:0]   s4 = '0, c4;
    logic         m4 = 1'b0, ov4, or4 = 1'b0;
    logic [63:0]  od4;
    logic [15:0]  n4;

    // 6-channel, 8-bit instance (non power of two, out-of-range sel)
    logic [47:0]  d6 = '0;
    logic [5:0]   v6 = '0, r6;
    logic [2:0]   s6 = '0, c6;
    logic         m6 = 1'b0, ov6, or6 = 1'b0;
    logic [7:0]   od6;
    logic [15:0]  n6;

    // 2-channel, 64-bit instance (legacy polarity)
    logic [127:0] d2 = '0;
    logic [1:0]   v2 = '0, r2;
    logic         s2 = 1'b0, c2, m2 = 1'b0, ov2, or2 = 1'b0;
    logic [63:0]  od2;
    logic [15:0]  n2;

    mux_nt1_pipe #(.WIDTH(64), .CH(4)) u4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(r4),
        .sel(s4), .mode(m4), .out_data(od4), .out_valid(ov4), .out_ready(or4),
        .out_ch(c4), .xfer_cnt(n4));

    mux_nt1_pipe #(.WIDTH(8), .CH(6)) u6 (
        .clk(clk), .rst(rst), .in_data(d6), .in_valid(v6), .in_ready(r6),
        .sel(s6), .mode(m6), .out_data(od6), .out_valid(ov6), .out_ready(or6),
        .out_ch(c6), .xfer_cnt(n6));

    mux_nt1_pipe #(.WIDTH(64), .CH(2)) u2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .sel(s2), .mode(m2), .out_data(od2), .out_valid(ov2), .out_ready(or2),
        .out_ch(c2), .xfer_cnt(n2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] dpat(input int i);
        return 64'hDEAD_BEEF_0000_0000 | 64'(i);
    endfunction

    // Raw sel that makes fixed mode pick channel ch on the 4-channel instance.
    function automatic logic [1:0] sel_for(input int ch);
        return INV ? 2'(3 - ch) : 2'(ch);
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        mode;
        int          ch_sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_ch;
        logic [63:0] e_dat;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic r, input logic m, input int cs, input logic [3:0] v,
                                input logic o, input logic [3:0] er, input logic eo,
                                input logic [1:0] ec, input logic [63:0] ed, input logic [15:0] en);
        vec_t t;
        t.rst = r; t.mode = m; t.ch_sel = cs; t.vld = v; t.ordy = o;
        t.e_rdy = er; t.e_ov = eo; t.e_ch = ec; t.e_dat = ed; t.e_cnt = en;
        return t;
    endfunction

    // ---------------- reference model (4-channel instance) ----------------
    bit          m_vld;
    logic [63:0] m_dat;
    int          m_ch, m_cnt, m_ptr;

    function automatic int m_pick(input logic md, input logic [1:0] sl, input logic [3:0] vl, input int ptr);
        int s;
        if (!md) begin
            s = int'(sl);
            if (s >= 4) return -1;
            return INV ? 3 - s : s;
        end
        for (int k = 0; k < 4; k++) begin
            if (vl[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int  c;
        bit  space, take, acc;
        logic [3:0] e_rdy;

        tbl[0]  = mk(1, 0, 2, 4'b0100, 1, 4'b0000, 0, 0, 64'h0, 0);
        tbl[1]  = mk(0, 0, 2, 4'b0100, 1, 4'b0100, 1, 2, dpat(2), 0);
        tbl[2]  = mk(0, 0, 2, 4'b0000, 1, 4'b0100, 0, 2, dpat(2), 1);
        tbl[3]  = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, dpat(0), 1);
        tbl[4]  = mk(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, dpat(1), 2);
        tbl[5]  = mk(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, dpat(2), 3);
        tbl[6]  = mk(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 3, dpat(3), 4);
        tbl[7]  = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, dpat(0), 5);
        tbl[8]  = mk(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, dpat(1), 6);
        tbl[9]  = mk(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, dpat(2), 7);
        tbl[10] = mk(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 3, dpat(3), 8);
        tbl[11] = mk(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 3, dpat(3), 8);
        tbl[12] = mk(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 3, dpat(3), 8);
        tbl[13] = mk(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 3, dpat(3), 8);
        tbl[14] = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, dpat(0), 9);
        tbl[15] = mk(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, dpat(0), 10);
        tbl[16] = mk(0, 1, 0, 4'b1010, 1, 4'b0010, 1, 1, dpat(1), 10);
        tbl[17] = mk(0, 1, 0, 4'b1010, 1, 4'b1000, 1, 3, dpat(3), 11);
        tbl[18] = mk(0, 1, 0, 4'b1010, 1, 4'b0010, 1, 1, dpat(1), 12);
        tbl[19] = mk(0, 0, 0, 4'b0000, 1, 4'b0001, 0, 1, dpat(1), 13);
        tbl[20] = mk(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, dpat(2), 13);
        tbl[21] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 0, 0, 64'h0, 0);
        tbl[22] = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, dpat(0), 0);

        for (int i = 0; i < 4; i++) d4[i*64 +: 64] = dpat(i);
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst; m4 = tbl[i].mode; s4 = sel_for(tbl[i].ch_sel);
            v4 = tbl[i].vld; or4 = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_rdy", i), 64'(r4), 64'(tbl[i].e_rdy));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_ov", i),  64'(ov4), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_ch", i),  64'(c4),  64'(tbl[i].e_ch));
            chk($sformatf("tbl%0d_dat", i), od4,      tbl[i].e_dat);
            chk($sformatf("tbl%0d_cnt", i), 64'(n4),  64'(tbl[i].e_cnt));
        end
        rst = 1'b0; v4 = '0; or4 = 1'b0;

        // ---------------- 6-channel: out-of-range and top-channel selects ----------------
        for (int i = 0; i < 6; i++) d6[i*8 +: 8] = 8'(8'h10 + i);
        m6 = 1'b0; s6 = 3'd7; v6 = '1; or6 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ch6_sel7_rdy", 64'(r6), 64'h0);
            @(posedge clk);
            @(negedge clk);
            chk("ch6_sel7_ov", 64'(ov6), 64'h0);
        end
        s6 = 3'd5;
        #1;
        chk("ch6_sel5_rdy", 64'(r6), INV ? 64'h01 : 64'h20);
        @(posedge clk);
        @(negedge clk);
        chk("ch6_sel5_ov",  64'(ov6), 64'h1);
        chk("ch6_sel5_ch",  64'(c6),  INV ? 64'd0 : 64'd5);
        chk("ch6_sel5_dat", 64'(od6), INV ? 64'h10 : 64'h15);
        s6 = 3'd6;
        #1;
        chk("ch6_sel6_rdy", 64'(r6), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("ch6_sel6_ov",  64'(ov6), 64'h0);
        chk("ch6_sel6_cnt", 64'(n6),  64'h1);
        v6 = '0; or6 = 1'b0;

        // ---------------- 2-channel polarity ----------------
        d2 = {64'h2, 64'h1}; v2 = 2'b11; m2 = 1'b0; or2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s2 = (k == 0) ? 1'b1 : 1'b0;
            #1;
            chk($sformatf("ch2_sel%0d_rdy", s2), 64'(r2), ((INV ^ s2) ? 64'h2 : 64'h1));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("ch2_sel%0d_dat", s2), od2, ((INV ^ s2) ? 64'h2 : 64'h1));
            chk($sformatf("ch2_sel%0d_ch", s2), 64'(c2), ((INV ^ s2) ? 64'h1 : 64'h0));
        end
        v2 = '0; or2 = 1'b0;

        // ---------------- randomized run against the model ----------------
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_vld = 0; m_dat = '0; m_ch = 0; m_cnt = 0; m_ptr = 0;
        for (int n = 0; n < 600; n++) begin
            rst = (n < 2) || ($urandom_range(0, 49) == 0);
            m4  = 1'($urandom_range(0, 1));
            s4  = 2'($urandom);
            v4  = 4'($urandom);
            or4 = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) d4[i*64 +: 64] = {$urandom, $urandom};
            #1;
            c = m_pick(m4, s4, v4, m_ptr);
            space = !m_vld || or4;
            e_rdy = (!rst && space && c >= 0) ? 4'(1 << c) : 4'h0;
            chk("rnd_rdy", 64'(r4), 64'(e_rdy));
            @(posedge clk);
            if (rst) begin
                m_vld = 0; m_dat = '0; m_ch = 0; m_cnt = 0; m_ptr = 0;
            end else begin
                take = m_vld && or4;
                acc  = (c >= 0) && space && v4[c];
                if (take && m_cnt < 65535) m_cnt++;
                if (acc) begin
                    m_dat = d4[c*64 +: 64];
                    m_ch  = c;
                    m_vld = 1;
                    if (m4) m_ptr = (c + 1) % 4;
                end else if (take) begin
                    m_vld = 0;
                end
            end
            @(negedge clk);
            chk("rnd_ov",  64'(ov4), 64'(m_vld));
            chk("rnd_ch",  64'(c4),  64'(m_ch));
            chk("rnd_dat", od4,      m_dat);
            chk("rnd_cnt", 64'(n4),  64'(m_cnt));
        end

        // ---------------- counter saturation ----------------
        rst = 1'b1; m4 = 1'b1; v4 = 4'hF; or4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("sat_near", 64'(n4), 64'd65534);
        @(posedge clk);
        @(negedge clk);
        chk("sat_full", 64'(n4), 64'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 64'(n4), 64'hFFFF);
        chk("sat_ov",   64'(ov4), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
